// File: rtl/lbm_step_sequencer.sv
// LBM time-step sequencer: runs collide -> stream -> boundary on the compute
// engines for each time step, then pulses the time-step counter's Enable.
// Stops when the counter reports MAX_TIME; a per-phase watchdog traps hung
// engines in a sticky error state.
module lbm_step_sequencer #(
   parameter int unsigned MAX_TIME         = 100,
   parameter int unsigned TIME_COUNT_WIDTH = $clog2(MAX_TIME),
   parameter int unsigned TIMEOUT_CYCLES   = 4096,
   parameter int unsigned WD_WIDTH         = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        start_i,
   input  logic                        abort_i,
   input  logic [TIME_COUNT_WIDTH:0]   time_count_i,
   input  logic                        collide_done_i,
   input  logic                        stream_done_i,
   input  logic                        boundary_done_i,
   output logic                        collide_start_o,
   output logic                        stream_start_o,
   output logic                        boundary_start_o,
   output logic                        step_enable_o,
   output logic                        busy_o,
   output logic                        sim_done_o,
   output logic                        timeout_err_o,
   output logic [2:0]                  phase_o
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CHECK    = 3'd1,
      S_COLLIDE  = 3'd2,
      S_STREAM   = 3'd3,
      S_BOUNDARY = 3'd4,
      S_ADVANCE  = 3'd5,
      S_DONE     = 3'd6,
      S_ERROR    = 3'd7
   } state_e;

   // A zero-timeout build still needs a one-bit counter to exist.
   localparam int unsigned WDW = (WD_WIDTH < 1) ? 1 : WD_WIDTH;

   state_e         state_q, state_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic           collide_start_q, collide_start_d;
   logic           stream_start_q, stream_start_d;
   logic           boundary_start_q, boundary_start_d;

   logic           phase_done;
   logic           wd_limit;
   logic           count_at_max;
   logic           next_in_phase;

   // Next-state, watchdog and start-pulse decode.
   always_comb begin
      state_d          = state_q;
      wd_d             = '0;
      collide_start_d  = 1'b0;
      stream_start_d   = 1'b0;
      boundary_start_d = 1'b0;
      phase_done       = 1'b0;
      next_in_phase    = 1'b0;

      // A done is honoured only in its own phase and never in the start cycle.
      unique case (state_q)
         S_COLLIDE:  phase_done = collide_done_i  & ~collide_start_q;
         S_STREAM:   phase_done = stream_done_i   & ~stream_start_q;
         S_BOUNDARY: phase_done = boundary_done_i & ~boundary_start_q;
         default:    phase_done = 1'b0;
      endcase

      wd_limit     = (TIMEOUT_CYCLES != 0) &&
                     ((32'(wd_q) + 32'd1) >= TIMEOUT_CYCLES);
      count_at_max = (32'(time_count_i) >= MAX_TIME);

      unique case (state_q)
         S_IDLE:     if (start_i) state_d = S_CHECK;
         S_CHECK:    state_d = count_at_max ? S_DONE : S_COLLIDE;
         S_COLLIDE:  if (phase_done) state_d = S_STREAM;
                     else if (wd_limit) state_d = S_ERROR;
         S_STREAM:   if (phase_done) state_d = S_BOUNDARY;
                     else if (wd_limit) state_d = S_ERROR;
         S_BOUNDARY: if (phase_done) state_d = S_ADVANCE;
                     else if (wd_limit) state_d = S_ERROR;
         S_ADVANCE:  state_d = S_CHECK;
         S_DONE:     state_d = S_DONE;
         S_ERROR:    state_d = S_ERROR;
         default:    state_d = S_IDLE;
      endcase

      if (abort_i) state_d = S_IDLE;

      next_in_phase = (state_d == S_COLLIDE) || (state_d == S_STREAM) ||
                      (state_d == S_BOUNDARY);

      // Watchdog restarts on phase entry and saturates instead of wrapping.
      if (next_in_phase) begin
         if (state_d != state_q) wd_d = '0;
         else if (wd_q == '1)    wd_d = wd_q;
         else                    wd_d = wd_q + WDW'(1);
      end

      collide_start_d  = (state_d == S_COLLIDE)  && (state_q != S_COLLIDE);
      stream_start_d   = (state_d == S_STREAM)   && (state_q != S_STREAM);
      boundary_start_d = (state_d == S_BOUNDARY) && (state_q != S_BOUNDARY);
   end

   // State, watchdog and start-pulse registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q          <= S_IDLE;
         wd_q             <= '0;
         collide_start_q  <= 1'b0;
         stream_start_q   <= 1'b0;
         boundary_start_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         wd_q             <= wd_d;
         collide_start_q  <= collide_start_d;
         stream_start_q   <= stream_start_d;
         boundary_start_q <= boundary_start_d;
      end
   end

   assign collide_start_o  = collide_start_q;
   assign stream_start_o   = stream_start_q;
   assign boundary_start_o = boundary_start_q;
   assign step_enable_o    = (state_q == S_ADVANCE);
   assign busy_o           = (state_q == S_CHECK)    || (state_q == S_COLLIDE) ||
                             (state_q == S_STREAM)   || (state_q == S_BOUNDARY) ||
                             (state_q == S_ADVANCE);
   assign sim_done_o       = (state_q == S_DONE);
   assign timeout_err_o    = (state_q == S_ERROR);
   assign phase_o          = state_q;

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// Bench for lbm_step_sequencer: builds a per-cycle expected timeline from the
// step rules (phase lengths from engine latency, pulses on phase entry) and
// replays it against the DUT, acting as the time-step counter itself.
module tb_lbm_step_sequencer;

   localparam int unsigned MAXT = 3;
   localparam int unsigned TCW  = $clog2(MAXT);
   localparam int unsigned TOUT = 8;

   typedef struct packed { logic [2:0] ph; logic [3:0] p; } exp_t; // p = {cs,ss,bs,se}
   typedef struct packed { logic st, ab, cd, sd, bd; } in_t;

   logic clk = 1'b0;
   logic rst_ni, start_i, abort_i, cd_i, sd_i, bd_i;
   logic [TCW:0] cnt;
   logic cs_o, ss_o, bs_o, se_o, busy_o, done_o, err_o;
   logic [2:0] phase_o;

   exp_t eq[$];
   in_t  iq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   lbm_step_sequencer #(
      .MAX_TIME(MAXT), .TIME_COUNT_WIDTH(TCW),
      .TIMEOUT_CYCLES(TOUT), .WD_WIDTH($clog2(TOUT + 1))
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
      .time_count_i(cnt), .collide_done_i(cd_i), .stream_done_i(sd_i),
      .boundary_done_i(bd_i), .collide_start_o(cs_o), .stream_start_o(ss_o),
      .boundary_start_o(bs_o), .step_enable_o(se_o), .busy_o(busy_o),
      .sim_done_o(done_o), .timeout_err_o(err_o), .phase_o(phase_o)
   );

   function automatic logic [9:0] actual();
      return {phase_o, cs_o, ss_o, bs_o, se_o, busy_o, done_o, err_o};
   endfunction

   function automatic logic [9:0] expv(exp_t e);
      return {e.ph, e.p, (e.ph >= 3'd1 && e.ph <= 3'd5), e.ph == 3'd6, e.ph == 3'd7};
   endfunction

   // mode 0: quiet, 1: random ignorable inputs, 2: every ignorable input high
   function automatic in_t noise(int mode);
      in_t iv = '0;
      if (mode == 1) begin
         iv.st = 1'($urandom_range(0, 1));
         iv.cd = 1'($urandom_range(0, 1));
         iv.sd = 1'($urandom_range(0, 1));
         iv.bd = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
         iv.st = 1'b1; iv.cd = 1'b1; iv.sd = 1'b1; iv.bd = 1'b1;
      end
      return iv;
   endfunction

   function automatic in_t set_own(in_t iv, logic [2:0] ph, logic v);
      in_t r = iv;
      case (ph)
         3'd2:    r.cd = v;
         3'd3:    r.sd = v;
         default: r.bd = v;
      endcase
      return r;
   endfunction

   task automatic add(input logic [2:0] ph, input logic [3:0] p, input in_t iv);
      exp_t e;
      e.ph = ph; e.p = p;
      eq.push_back(e);
      iq.push_back(iv);
   endtask

   // Phase lasts lat+1 cycles: start pulse in cycle 0, engine done in cycle lat.
   task automatic add_phase(input logic [2:0] ph, input int unsigned lat, input int mode,
                            input bit withhold, input bit abort_last);
      for (int unsigned j = 0; j <= lat; j++) begin
         in_t iv;
         logic [3:0] p;
         iv = noise(mode);
         p  = '0;
         if (j == 0) p = (ph == 3'd2) ? 4'b1000 : (ph == 3'd3) ? 4'b0100 : 4'b0010;
         else iv = set_own(iv, ph, (j == lat) && !withhold);
         if (j == lat) iv.ab = abort_last;
         add(ph, p, iv);
      end
   endtask

   function automatic int unsigned pick_lat(int unsigned lat);
      return (lat != 0) ? lat : $urandom_range(1, TOUT - 1);
   endfunction

   task automatic build_sim(input int unsigned c0, input int mode, input int unsigned lat);
      in_t go = '0;
      int unsigned steps;
      go.st = 1'b1;
      cnt = (TCW + 1)'(c0);
      steps = (c0 >= MAXT) ? 0 : MAXT - c0;
      add(3'd0, 4'b0000, go);
      repeat (steps) begin
         add(3'd1, 4'b0000, noise(mode));
         add_phase(3'd2, pick_lat(lat), mode, 0, 0);
         add_phase(3'd3, pick_lat(lat), mode, 0, 0);
         add_phase(3'd4, pick_lat(lat), mode, 0, 0);
         add(3'd5, 4'b0001, noise(mode));
      end
      add(3'd1, 4'b0000, noise(mode));
      repeat (4) add(3'd6, 4'b0000, noise((mode == 0) ? 1 : mode));
   endtask

   // Replays the timeline; the bench increments the count after each Enable cycle.
   task automatic run(input string name);
      bit se_seen = 1'b0;
      for (int i = 0; i < eq.size(); i++) begin
         @(posedge clk); #1;
         if (se_seen) cnt = cnt + 1'b1;
         n_checks++;
         if (actual() !== expv(eq[i])) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got ph/cs,ss,bs,se/busy,done,err=%b required %b",
                     name, i, actual(), expv(eq[i]));
         end
         se_seen = se_o;
         {start_i, abort_i, cd_i, sd_i, bd_i} = iq[i];
      end
      eq.delete();
      iq.delete();
   endtask

   task automatic check_cnt(input string name, input int unsigned want);
      n_checks++;
      if (cnt !== (TCW + 1)'(want)) begin
         n_fail++;
         $display("FAIL %s: count got %0d required %0d", name, cnt, want);
      end
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      {start_i, abort_i, cd_i, sd_i, bd_i} = '0;
      cnt = '0;
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; start_i = 1'b1; abort_i = 1'b0;
      {cd_i, sd_i, bd_i} = '0; cnt = '0;
      #1;
      n_checks++;
      if (actual() !== 10'd0) begin
         n_fail++; $display("FAIL reset_now: got %b required 0", actual());
      end
      repeat (3) @(posedge clk); #1;
      n_checks++;
      if (actual() !== 10'd0) begin
         n_fail++; $display("FAIL reset_held: got %b required 0", actual());
      end
      @(negedge clk); rst_ni = 1'b1; start_i = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (actual() !== 10'd0) begin
         n_fail++; $display("FAIL reset_release: got %b required 0", actual());
      end
   endtask

   task automatic test_full_run();
      for (int k = 0; k < 4; k++) begin
         do_reset();
         build_sim($urandom_range(0, 2), 1, 0);
         run("full_run");
         check_cnt("full_run_count", MAXT);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      build_sim(0, 2, 1);
      run("back_to_back");
      check_cnt("back_to_back_count", MAXT);
   endtask

   task automatic test_timeout();
      in_t go = '0, ab = '0;
      go.st = 1'b1; ab.ab = 1'b1;
      do_reset();
      add(3'd0, 4'b0000, go);
      add(3'd1, 4'b0000, noise(1));
      add_phase(3'd2, TOUT - 1, 1, 0, 0);
      add_phase(3'd3, TOUT - 1, 1, 1, 0);
      repeat (3) add(3'd7, 4'b0000, noise(2));
      add(3'd7, 4'b0000, ab);
      repeat (2) add(3'd0, 4'b0000, '0);
      run("timeout");
      check_cnt("timeout_count", 0);
   endtask

   task automatic test_abort();
      in_t go = '0;
      int unsigned p;
      go.st = 1'b1;
      do_reset();
      add(3'd0, 4'b0000, go);
      add(3'd1, 4'b0000, noise(1));
      add_phase(3'd2, 2, 1, 0, 0);
      add_phase(3'd3, 1, 1, 0, 0);
      add_phase(3'd4, 3, 1, 0, 1);
      repeat (2) add(3'd0, 4'b0000, '0);
      run("abort_boundary");
      check_cnt("abort_boundary_count", 0);

      do_reset();
      p = $urandom_range(2, 4);
      add(3'd0, 4'b0000, go);
      add(3'd1, 4'b0000, noise(1));
      for (int unsigned ph = 2; ph <= p; ph++)
         add_phase(3'(ph), pick_lat(0), 1, 0, ph == p);
      repeat (2) add(3'd0, 4'b0000, '0);
      run("abort_random");
      check_cnt("abort_random_count", 0);

      do_reset();
      add(3'd0, 4'b0000, go);
      add(3'd1, 4'b0000, '0);
      add_phase(3'd2, 1, 0, 0, 0);
      add_phase(3'd3, 1, 0, 0, 0);
      add_phase(3'd4, 1, 0, 0, 0);
      add(3'd5, 4'b0001, '0);
      run("pre_async_reset");
      #2 rst_ni = 1'b0;
      #1;
      n_checks++;
      if (se_o !== 1'b0) begin
         n_fail++; $display("FAIL async_reset_se: got %b required 0", se_o);
      end
      n_checks++;
      if (phase_o !== 3'd0) begin
         n_fail++; $display("FAIL async_reset_phase: got %0d required 0", phase_o);
      end
      do_reset();
      @(posedge clk); #1;
      check_cnt("async_reset_count", 0);
   endtask

   task automatic test_start_at_max();
      do_reset();
      build_sim(MAXT, 1, 0);
      run("start_at_max");
      check_cnt("start_at_max_count", MAXT);
      do_reset();
      build_sim(MAXT + 2, 2, 0);
      run("start_above_max");
      check_cnt("start_above_max_count", MAXT + 2);
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_back_to_back();
      test_timeout();
      test_abort();
      test_start_at_max();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
